// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID / uptime peripheral: register word
// offsets, CTRL bit positions, counter width and a byte-lane merge helper.
package sysid_pkg;

    localparam int CNT_W        = 64;

    localparam int REG_SYSID    = 0;
    localparam int REG_TSTAMP   = 1;
    localparam int REG_CTRL     = 2;
    localparam int REG_UP_LO    = 3;
    localparam int REG_UP_HI    = 4;
    localparam int REG_SCRATCH0 = 5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_PEND    = 9;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// 64-bit free-running uptime counter with clear/enable, and the high-word
// shadow captured whenever software reads the low word.
// Optional macro SYSID_UPTIME_IRQ_EN adds the compare match, the sticky
// pending flag and the registered irq output.
module sysid_uptime_ctr
    import sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
`ifdef SYSID_UPTIME_IRQ_EN
    input  logic [31:0] compare,
    input  logic        pend_clr,
    input  logic        irq_en,
    output logic        pending,
    output logic        irq,
`endif
    output logic [31:0] count_lo,
    output logic [31:0] shadow_hi
);

    logic [CNT_W-1:0] count_reg;
    logic [31:0]      shadow_reg;

    // Counter: clear takes priority over the increment; wraps naturally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Shadow of the upper word, taken at the same edge the low word is returned.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow_reg <= '0;
        end else if (snap) begin
            shadow_reg <= count_reg[CNT_W-1:32];
        end
    end

    assign count_lo  = count_reg[31:0];
    assign shadow_hi = shadow_reg;

`ifdef SYSID_UPTIME_IRQ_EN
    logic pending_reg;
    logic irq_reg;

    // Sticky match flag; a match in the same cycle as a clear keeps it set.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_reg <= 1'b0;
        end else if (en && (count_reg[31:0] == compare)) begin
            pending_reg <= 1'b1;
        end else if (pend_clr) begin
            pending_reg <= 1'b0;
        end
    end

    // Interrupt line is a registered, masked copy of the pending flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= pending_reg & irq_en;
        end
    end

    assign pending = pending_reg;
    assign irq     = irq_reg;
`endif

endmodule

// File: rtl/sysid_uptime_slave.sv
// System-ID peripheral on Avalon-MM: build ID and timestamp, a 64-bit uptime
// counter with coherent lo/hi reads, CTRL and scratch registers. Reads return
// one cycle after the strobe with readdatavalid; there is no waitrequest.
// Optional macro SYSID_UPTIME_IRQ_EN adds the COMPARE register (after the
// scratch block), CTRL irq_en/pending bits and the irq output.
module sysid_uptime_slave
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int          NUM_SCRATCH = 2,
    parameter int          ADDR_W      = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
`ifdef SYSID_UPTIME_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

    localparam logic [ADDR_W-1:0] A_SYSID  = ADDR_W'(REG_SYSID);
    localparam logic [ADDR_W-1:0] A_TSTAMP = ADDR_W'(REG_TSTAMP);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] A_UP_LO  = ADDR_W'(REG_UP_LO);
    localparam logic [ADDR_W-1:0] A_UP_HI  = ADDR_W'(REG_UP_HI);

    // A write colliding with a read is dropped; the read is served.
    logic wr_en;
    logic wr_ctrl;
    logic clr_pulse;
    logic snap;
    logic en_reg;
    logic [31:0] count_lo;
    logic [31:0] shadow_hi;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_mux;
    logic [32*SCR_N-1:0] scratch_flat;

    assign wr_en     = write & ~read;
    assign wr_ctrl   = wr_en && (address == A_CTRL);
    assign clr_pulse = wr_ctrl & byteenable[0] & writedata[CTRL_CLR];
    assign snap      = read && (address == A_UP_LO);

    // CTRL.en: counting enabled out of reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            en_reg <= 1'b1;
        end else if (wr_ctrl && byteenable[0]) begin
            en_reg <= writedata[CTRL_EN];
        end
    end

    // Scratch registers, one generated instance per word.
    genvar gi;
    generate
        for (gi = 0; gi < SCR_N; gi++) begin : g_scr
            if (gi < NUM_SCRATCH) begin : g_rw
                logic [31:0] val_reg;
                // Byte-enabled software storage.
                always_ff @(posedge clock) begin
                    if (!reset_n) begin
                        val_reg <= '0;
                    end else if (wr_en && (address == ADDR_W'(REG_SCRATCH0 + gi))) begin
                        val_reg <= be_merge(val_reg, writedata, byteenable);
                    end
                end
                assign scratch_flat[32*gi +: 32] = val_reg;
            end else begin : g_none
                assign scratch_flat[32*gi +: 32] = '0;
            end
        end
    endgenerate

`ifdef SYSID_UPTIME_IRQ_EN
    localparam logic [ADDR_W-1:0] A_CMP = ADDR_W'(REG_SCRATCH0 + NUM_SCRATCH);

    logic        irq_en_reg;
    logic [31:0] compare_reg;
    logic        pend_clr;
    logic        pending;

    assign pend_clr = wr_ctrl & byteenable[1] & writedata[CTRL_PEND];

    // CTRL.irq_en and the COMPARE register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_en_reg  <= 1'b0;
            compare_reg <= 32'hFFFF_FFFF;
        end else begin
            if (wr_ctrl && byteenable[0]) irq_en_reg <= writedata[CTRL_IRQ_EN];
            if (wr_en && (address == A_CMP)) begin
                compare_reg <= be_merge(compare_reg, writedata, byteenable);
            end
        end
    end
`endif

    sysid_uptime_ctr u_ctr (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en_reg),
        .clr       (clr_pulse),
        .snap      (snap),
`ifdef SYSID_UPTIME_IRQ_EN
        .compare   (compare_reg),
        .pend_clr  (pend_clr),
        .irq_en    (irq_en_reg),
        .pending   (pending),
        .irq       (irq),
`endif
        .count_lo  (count_lo),
        .shadow_hi (shadow_hi)
    );

    // CTRL readback: clr always reads 0.
    always_comb begin
        ctrl_rd          = '0;
        ctrl_rd[CTRL_EN] = en_reg;
`ifdef SYSID_UPTIME_IRQ_EN
        ctrl_rd[CTRL_IRQ_EN] = irq_en_reg;
        ctrl_rd[CTRL_PEND]   = pending;
`endif
    end

    // Read mux; unmapped words return 0.
    always_comb begin
        rd_mux = '0;
        if (address == A_SYSID)       rd_mux = SYSTEM_ID;
        else if (address == A_TSTAMP) rd_mux = TIMESTAMP;
        else if (address == A_CTRL)   rd_mux = ctrl_rd;
        else if (address == A_UP_LO)  rd_mux = count_lo;
        else if (address == A_UP_HI)  rd_mux = shadow_hi;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == ADDR_W'(REG_SCRATCH0 + i)) rd_mux = scratch_flat[32*i +: 32];
        end
`ifdef SYSID_UPTIME_IRQ_EN
        if (address == A_CMP) rd_mux = compare_reg;
`endif
    end

    // Registered read response, one cycle after the strobe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) readdata <= rd_mux;
        end
    end

endmodule
